fma_add_pipe: RTL

FMA_ADD_PIPE -- requirements
Module: fma_add_pipe

---
 rtl/fma_pkg.sv | 26 ++
 rtl/fma_lzc.sv | 33 +++
 rtl/fma_add_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fma_pkg
//  Description : Shared defaults and sizing helpers for the FMA lane adder.
//                Provides the lane count / width defaults, the leading-zero
//                count width function and the lane-slice offset helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fma_pkg;

    localparam int LANES_DEFAULT  = 4;
    localparam int LANE_W_DEFAULT = 24;
    localparam int EXP_W_DEFAULT  = 13;

    // Width of a leading-zero count able to represent 0..w inclusive.
    function automatic int lop_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Low bit index of a lane's field inside a flattened multi-lane bus.
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fma_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fma_lzc
//  Description : Parametrised leading-zero counter. Returns W for an
//                all-zero input.
//  Revision    : 1.0 - initial release
// ============================================================================
module fma_lzc
    import fma_pkg::*;
#(
    parameter int W     = 24,
    parameter int CNT_W = lop_w(W)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] cnt
);

    logic found;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        cnt   = CNT_W'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && din[i]) begin
                cnt   = CNT_W'(W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fma_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fma_add_pipe
//  Description : Two-stage multi-lane adder closing a fused multiply-add.
//                Stage 1 compresses the carry-save product with the aligned
//                addend and forms a LANE_W+1-bit raw sum per lane. Stage 2
//                normalises the magnitude, fixes sign/zero, adjusts and
//                saturates the exponent and counts leading zeros.
//                Optional feature macro: FMA_ADD_STICKY_EN adds a per-lane
//                sticky bit carried alongside the data.
//  Revision    : 1.0 - initial release
// ============================================================================
module fma_add_pipe
    import fma_pkg::*;
#(
    parameter  int LANES  = LANES_DEFAULT,
    parameter  int LANE_W = LANE_W_DEFAULT,
    parameter  int EXP_W  = EXP_W_DEFAULT,
    localparam int LOP_W  = lop_w(LANE_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        lane_en,
    input  logic [LANES*LANE_W-1:0] p_sum,
    input  logic [LANES*LANE_W-1:0] p_carry,
    input  logic [LANES*LANE_W-1:0] addend,
    input  logic [LANES-1:0]        sign_p,
    input  logic [LANES-1:0]        sign_c,
    input  logic [LANES*EXP_W-1:0]  exp_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] sum_out,
    output logic [LANES*EXP_W-1:0]  exp_out,
    output logic [LANES-1:0]        sign_out,
    output logic [LANES-1:0]        zero_out,
    output logic [LANES-1:0]        of_out,
    output logic [LANES*LOP_W-1:0]  lzc_out
`ifdef FMA_ADD_STICKY_EN
    ,
    input  logic [LANES-1:0]        sticky_in,
    output logic [LANES-1:0]        sticky_out
`else
    // no sticky ports in this build
`endif
);

    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic accept;
    logic load2;

    // Stage 2 may take a new beat when empty or when its result is consumed;
    // stage 1 may accept whenever that frees or leaves it free.
    assign in_ready  = ~v1_q | ~v2_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign load2     = ~v2_q | out_ready;
    assign out_valid = v2_q;

    // Valid-flag next state for both stages.
    always_comb begin
        v1_d = v1_q;
        if (accept) begin
            v1_d = 1'b1;
        end else if (load2) begin
            v1_d = 1'b0;
        end
        v2_d = load2 ? v1_q : v2_q;
    end

    // Valid-flag registers; reset discards any beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int SL = lane_lo(l, LANE_W);
        localparam int EL = lane_lo(l, EXP_W);
        localparam int ZL = lane_lo(l, LOP_W);

        logic              op_in;
        logic [LANE_W-1:0] opa, opb, opc, csa_s, csa_c;
        logic [LANE_W:0]   raw_new;

        logic [LANE_W:0]   raw_q, raw_d;
        logic              op_q, op_d;
        logic              sp_q, sp_d;
        logic              sc_q, sc_d;
        logic              en_q, en_d;
        logic [EXP_W-1:0]  exp1_q, exp1_d;

        logic              co;
        logic              inc;
        logic [LANE_W-1:0] lo;
        logic [LANE_W-1:0] sum_n;
        logic [EXP_W-1:0]  exp_n;
        logic              sign_n, zero_n, of_n;
        logic [LOP_W-1:0]  lzc_n;

        logic [LANE_W-1:0] sum_q, sum_d;
        logic [EXP_W-1:0]  exp2_q, exp2_d;
        logic              sign_q, sign_d;
        logic              zero_q, zero_d;
        logic              of_q, of_d;
        logic [LOP_W-1:0]  lzc_q, lzc_d;

        // Stage 1: 3:2 compression then carry-propagate add, lane-local.
        always_comb begin
            op_in   = sign_p[l] ^ sign_c[l];
            opa     = p_sum[SL +: LANE_W];
            opb     = p_carry[SL +: LANE_W];
            opc     = op_in ? ~addend[SL +: LANE_W] : addend[SL +: LANE_W];
            csa_s   = opa ^ opb ^ opc;
            csa_c   = (opa & opb) | (opa & opc) | (opb & opc);
            raw_new = {1'b0, csa_s} + {csa_c, 1'b0} + {{LANE_W{1'b0}}, op_in};
            raw_d   = raw_q;
            op_d    = op_q;
            sp_d    = sp_q;
            sc_d    = sc_q;
            en_d    = en_q;
            exp1_d  = exp1_q;
            if (accept) begin
                raw_d  = raw_new;
                op_d   = op_in;
                sp_d   = sign_p[l];
                sc_d   = sign_c[l];
                en_d   = lane_en[l];
                exp1_d = exp_in[EL +: EXP_W];
            end
        end

        // Stage 1 registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                raw_q  <= '0;
                op_q   <= 1'b0;
                sp_q   <= 1'b0;
                sc_q   <= 1'b0;
                en_q   <= 1'b0;
                exp1_q <= '0;
            end else begin
                raw_q  <= raw_d;
                op_q   <= op_d;
                sp_q   <= sp_d;
                sc_q   <= sc_d;
                en_q   <= en_d;
                exp1_q <= exp1_d;
            end
        end

        // Stage 2: select magnitude and sign, then zero and exponent fix-up.
        always_comb begin
            co    = raw_q[LANE_W];
            lo    = raw_q[LANE_W-1:0];
            inc   = ~op_q & co;
            sum_n = lo;
            if (inc) begin
                sum_n = {1'b1, raw_q[LANE_W-1:1]};
            end else if (op_q & ~co) begin
                sum_n = ~lo + LANE_W'(1);
            end
            sign_n = (op_q & ~co) ? sc_q : sp_q;
            zero_n = (sum_n == '0);
            if (zero_n) begin
                sign_n = op_q ? 1'b0 : (sp_q & sc_q);
            end
            exp_n = exp1_q;
            of_n  = 1'b0;
            if (inc) begin
                if (&exp1_q) begin
                    of_n = 1'b1;
                end else begin
                    exp_n = exp1_q + EXP_W'(1);
                end
            end
        end

        fma_lzc #(
            .W     (LANE_W),
            .CNT_W (LOP_W)
        ) u_lzc (
            .din (sum_n),
            .cnt (lzc_n)
        );

        // Stage 2 next state: load on advance, zero fields for disabled lanes.
        always_comb begin
            sum_d  = sum_q;
            exp2_d = exp2_q;
            sign_d = sign_q;
            zero_d = zero_q;
            of_d   = of_q;
            lzc_d  = lzc_q;
            if (load2 && v1_q) begin
                if (en_q) begin
                    sum_d  = sum_n;
                    exp2_d = exp_n;
                    sign_d = sign_n;
                    zero_d = zero_n;
                    of_d   = of_n;
                    lzc_d  = lzc_n;
                end else begin
                    sum_d  = '0;
                    exp2_d = '0;
                    sign_d = 1'b0;
                    zero_d = 1'b0;
                    of_d   = 1'b0;
                    lzc_d  = '0;
                end
            end
        end

        // Stage 2 (output) registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q  <= '0;
                exp2_q <= '0;
                sign_q <= 1'b0;
                zero_q <= 1'b0;
                of_q   <= 1'b0;
                lzc_q  <= '0;
            end else begin
                sum_q  <= sum_d;
                exp2_q <= exp2_d;
                sign_q <= sign_d;
                zero_q <= zero_d;
                of_q   <= of_d;
                lzc_q  <= lzc_d;
            end
        end

        assign sum_out[SL +: LANE_W] = sum_q;
        assign exp_out[EL +: EXP_W]  = exp2_q;
        assign sign_out[l]           = sign_q;
        assign zero_out[l]           = zero_q;
        assign of_out[l]             = of_q;
        assign lzc_out[ZL +: LOP_W]  = lzc_q;

`ifdef FMA_ADD_STICKY_EN
        logic stk1_q, stk1_d;
        logic stk2_q, stk2_d;

        // Sticky follows the data; the normalising shift may drop a set LSB.
        always_comb begin
            stk1_d = accept ? sticky_in[l] : stk1_q;
            stk2_d = stk2_q;
            if (load2 && v1_q) begin
                stk2_d = en_q & (stk1_q | (inc & raw_q[0]));
            end
        end

        // Sticky registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stk1_q <= 1'b0;
                stk2_q <= 1'b0;
            end else begin
                stk1_q <= stk1_d;
                stk2_q <= stk2_d;
            end
        end

        assign sticky_out[l] = stk2_q;
`endif
    end

endmodule
`default_nettype wire
